// File: rtl/req_ack_32bit_receiver.sv
// Four-phase request/acknowledge receiver: pairs 32-bit halves into 64-bit words,
// delimits frames by length or idle timeout, and streams them out through a FWFT FIFO.
module req_ack_32bit_receiver #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] recv_len,
  input  logic        request,
  input  logic [31:0] din,
  output logic        acknowledge,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  output logic        rx_hsked,
  output logic [31:0] data_cnt,
  output logic [31:0] tlast_cnt,
  output logic        o_half_err,
  output logic        o_rx_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            req_meta_q, req_s_q;
  logic            half_q, half_d;
  logic [31:0]     hi_q, hi_d;
  logic [63:0]     hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic [31:0]     words_in_q, words_in_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [31:0]     data_cnt_q, data_cnt_d;
  logic [31:0]     tlast_cnt_q, tlast_cnt_d;

  logic [64:0]     mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;

  logic [63:0]     word_w;
  logic [64:0]     push0, push1;
  logic [1:0]      push_n;
  logic [1:0]      need_n;
  logic [CW:0]     free_n;
  logic            pop, is_last, hit, space, capture, count_en, half_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
    end else begin
      req_meta_q <= request;
      req_s_q    <= req_meta_q;
    end
  end

  assign pop      = (count_q != '0) && m_axis_tready;
  assign free_n   = DEPTH_W - {1'b0, count_q} + (CW + 1)'(pop);
  assign word_w   = {hi_q, din};
  assign is_last  = (recv_len != 32'd0) && (words_in_q + 32'd1 == recv_len);
  assign hit      = (idle_cnt_q == TW'(TIMEOUT));
  // A second half may force one or two pushes; it is only taken if they all fit.
  assign need_n   = half_q ? ({1'b0, hold_valid_q} + {1'b0, is_last}) : 2'd0;
  assign space    = free_n >= (CW + 1)'(need_n);
  // Captures wait while a timeout action is pending so a flushed word keeps its tlast.
  assign capture  = (state_q == IDLE) && req_s_q && space && !hit;
  assign count_en = (state_q == IDLE) && !req_s_q && (hold_valid_q || half_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)  state_d = ACK;
      ACK:     if (!req_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acknowledge = (state_q == ACK);
  end

  always_comb begin
    half_d       = half_q;
    hi_d         = hi_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    words_in_d   = words_in_q;
    idle_cnt_d   = idle_cnt_q;
    push_n       = 2'd0;
    push0        = {1'b0, hold_q};
    push1        = {1'b1, word_w};
    half_err     = 1'b0;
    if (capture) begin
      idle_cnt_d = '0;
      if (!half_q) begin
        hi_d   = din;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
        if (is_last) begin
          if (hold_valid_q) begin
            push_n = 2'd2;
          end else begin
            push0  = {1'b1, word_w};
            push_n = 2'd1;
          end
          hold_valid_d = 1'b0;
          words_in_d   = 32'd0;
        end else begin
          if (hold_valid_q) push_n = 2'd1;
          hold_d       = word_w;
          hold_valid_d = 1'b1;
          words_in_d   = words_in_q + 32'd1;
        end
      end
    end else if (hit) begin
      half_err = half_q;
      half_d   = 1'b0;
      if (!hold_valid_q) begin
        idle_cnt_d = '0;
      end else if (free_n != '0) begin
        push0        = {1'b1, hold_q};
        push_n       = 2'd1;
        hold_valid_d = 1'b0;
        words_in_d   = 32'd0;
        idle_cnt_d   = '0;
      end
    end else if (count_en) begin
      idle_cnt_d = idle_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_q       <= 1'b0;
      hi_q         <= 32'd0;
      hold_q       <= 64'd0;
      hold_valid_q <= 1'b0;
      words_in_q   <= 32'd0;
      idle_cnt_q   <= '0;
      data_cnt_q   <= 32'd0;
      tlast_cnt_q  <= 32'd0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      half_q       <= half_d;
      hi_q         <= hi_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      words_in_q   <= words_in_d;
      idle_cnt_q   <= idle_cnt_d;
      data_cnt_q   <= data_cnt_d;
      tlast_cnt_q  <= tlast_cnt_d;
      wptr_q       <= wptr_q + AW'(push_n);
      rptr_q       <= rptr_q + AW'(pop);
      count_q      <= count_q + CW'(push_n) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_n != 2'd0) mem_q[wptr_q] <= push0;
    if (push_n == 2'd2) mem_q[wptr_q + AW'(1)] <= push1;
  end

  always_comb begin
    m_axis_tvalid = (count_q != '0);
    m_axis_tdata  = m_axis_tvalid ? mem_q[rptr_q][63:0] : 64'd0;
    m_axis_tlast  = m_axis_tvalid && mem_q[rptr_q][64];
    rx_hsked      = pop;
    o_rx_done     = pop && m_axis_tlast;
    o_half_err    = half_err;
  end

  // A tlast handshake closes the frame, so its clear wins over the increment.
  always_comb begin
    data_cnt_d  = data_cnt_q;
    tlast_cnt_d = tlast_cnt_q;
    if (o_rx_done) begin
      data_cnt_d  = 32'd0;
      tlast_cnt_d = tlast_cnt_q + 32'd1;
    end else if (rx_hsked) begin
      data_cnt_d  = data_cnt_q + 32'd1;
    end
  end

  assign data_cnt  = data_cnt_q;
  assign tlast_cnt = tlast_cnt_q;

endmodule
